yuv_rgb: RTL

Pipelined fixed-point YUV-to-RGB converter; the inverse of the RGB-to-YUV stage in the video datapath. It accepts 16-bit unsigned luma and 17-bit signed chroma difference samples (Q15-scaled BT.601 analog YUV) and reconstructs 16-bit unsigned R/G/B. The datapath uses multiplierless shift-add, carries a valid flag down a fixed 4-stage pipeline, and saturates results to the output range.

---
 rtl/yuv_rgb.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/yuv_rgb.sv
// yuv_rgb: pipelined fixed-point YUV -> RGB converter (inverse of the RGB-to-YUV stage).
// 16-bit unsigned Y and 17-bit signed U/V, all Q15 BT.601 analog scaling, give 16-bit R/G/B.
// The constant products are built from shifts and adds. The pipeline has four register
// stages, so the latency is 4 cycles and the throughput is one sample per clock.
// Optional macro YUV_RGB_SAT_EN: when defined, each channel clamps to 0..65535 and the
// clip flag is driven. When undefined, each channel wraps modulo 2^16 and clip is tied to 0.
//
// Coefficient decompositions (Q15):
//   KRV = 37356 = 2^15 + 2^12 + 2^8 + 2^7 + 2^6 + 2^5 + 2^3 + 2^2
//   KGU = 12943 = 2^13 + 2^12 + 2^9 + 2^7 + 2^4 - 2^0
//   KGV = 19038 = 2^14 + 2^11 + 2^9 + 2^6 + 2^5 - 2^1
//   KBU = 66585 = 2^16 + 2^10 + 2^4 + 2^3 + 2^0

module yuv_rgb (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [15:0] ydata,
   input  logic [16:0] udata,
   input  logic [16:0] vdata,
   output logic        out_valid,
   output logic [15:0] rdata,
   output logic [15:0] gdata,
   output logic [15:0] bdata,
   output logic        clip
);

   localparam int W = 36;
`ifdef YUV_RGB_SAT_EN
   // keep the full shifted result so the clamp can see the out-of-range bits
   localparam int QW = 21;
`else
   // wrap only needs the low 16 bits of the shifted result
   localparam int QW = 16;
`endif

   logic signed [W-1:0] y_x, u_x, v_x;

   assign y_x = {20'd0, ydata};
   assign u_x = {{19{udata[16]}}, udata};
   assign v_x = {{19{vdata[16]}}, vdata};

   logic v1, v2, v3;

   logic signed [W-1:0] r_p0, r_p1, r_p2, r_p3;
   logic signed [W-1:0] g_p0, g_p1, g_p2, g_p3;
   logic signed [W-1:0] b_p0, b_p1, b_p2;

   logic signed [W-1:0] r_s0, r_s1, g_s0, g_s1, b_s0, b_s1;

   logic signed [QW-1:0] r_q, g_q, b_q;

   logic [15:0] r_c, g_c, b_c;
   logic        clip_c;

   // valid flag shift chain, cleared by reset so in-flight samples are dropped
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         v3 <= 1'b0;
      end else begin
         v1 <= in_valid;
         v2 <= v1;
         v3 <= v2;
      end
   end

   // stage 1: capture inputs as partial shift-add terms (Y folded into the first term)
   always_ff @(posedge clock) begin
      r_p0 <= (y_x <<< 15) + (v_x <<< 15);
      r_p1 <= (v_x <<< 12) + (v_x <<< 8);
      r_p2 <= (v_x <<< 7) + (v_x <<< 6);
      r_p3 <= (v_x <<< 5) + (v_x <<< 3) + (v_x <<< 2);

      g_p0 <= (y_x <<< 15) - (u_x <<< 13) - (u_x <<< 12);
      g_p1 <= u_x - (u_x <<< 9) - (u_x <<< 7) - (u_x <<< 4);
      g_p2 <= -(v_x <<< 14) - (v_x <<< 11) - (v_x <<< 9);
      g_p3 <= (v_x <<< 1) - (v_x <<< 6) - (v_x <<< 5);

      b_p0 <= (y_x <<< 15) + (u_x <<< 16);
      b_p1 <= (u_x <<< 10) + (u_x <<< 4);
      b_p2 <= (u_x <<< 3) + u_x;
   end

   // stage 2: pairwise sums of the partial terms
   always_ff @(posedge clock) begin
      r_s0 <= r_p0 + r_p1;
      r_s1 <= r_p2 + r_p3;
      g_s0 <= g_p0 + g_p1;
      g_s1 <= g_p2 + g_p3;
      b_s0 <= b_p0 + b_p1;
      b_s1 <= b_p2;
   end

   // stage 3: final sum, round to nearest, arithmetic shift back to integer scale
   always_ff @(posedge clock) begin
      r_q <= QW'((r_s0 + r_s1 + 36'sd16384) >>> 15);
      g_q <= QW'((g_s0 + g_s1 + 36'sd16384) >>> 15);
      b_q <= QW'((b_s0 + b_s1 + 36'sd16384) >>> 15);
   end

`ifdef YUV_RGB_SAT_EN
   function automatic logic [16:0] sat16(input logic signed [20:0] x);
      logic [16:0] res;
      if (x[20])
         res = {1'b1, 16'h0000};
      else if (|x[19:16])
         res = {1'b1, 16'hffff};
      else
         res = {1'b0, x[15:0]};
      return res;
   endfunction

   // stage 4 combinational: clamp each channel and collect the clip flags
   always_comb begin
      logic [16:0] rs, gs, bs;
      rs = sat16(r_q);
      gs = sat16(g_q);
      bs = sat16(b_q);
      r_c = rs[15:0];
      g_c = gs[15:0];
      b_c = bs[15:0];
      clip_c = rs[16] | gs[16] | bs[16];
   end

   // clip register: follows the sample flag on valid cycles, forced low otherwise
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         clip <= 1'b0;
      else if (v3)
         clip <= clip_c;
      else
         clip <= 1'b0;
   end
`else
   // stage 4 combinational: modular wrap, the low 16 bits pass straight through
   always_comb begin
      r_c = r_q;
      g_c = g_q;
      b_c = b_q;
      clip_c = 1'b0;
   end

   assign clip = clip_c;
`endif

   // stage 4 output register: data updates only with a valid sample, holds otherwise
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         rdata     <= 16'd0;
         gdata     <= 16'd0;
         bdata     <= 16'd0;
      end else begin
         out_valid <= v3;
         if (v3) begin
            rdata <= r_c;
            gdata <= g_c;
            bdata <= b_c;
         end
      end
   end

endmodule
